// File: rtl/sccb_master.sv
// -----------------------------------------------------------------------------
// sccb_master
// SCCB/I2C-style register-access master for the camera control path. Each
// accepted command performs one 16-bit-address register write or read on the
// camera's SCL/SDA. Those lines are driven through split pad signals.
//
// Ports
//   clk, rstn          : block clock, synchronous active-low reset
//   cmd_valid/ready    : command handshake (see below)
//   cmd_rw             : 0 = write, 1 = read
//   cmd_addr[15:0]     : register address, MSB byte sent first
//   cmd_wdata[7:0]     : write data (ignored for reads)
//   rsp_valid          : one-cycle completion pulse
//   rsp_rdata[7:0]     : read data, held until the next read completes
//   rsp_nack           : OR of the 9th-bit samples of all master-sent bytes
//   busy               : inverse of cmd_ready
//   sccb_clk/_en       : SCL value / SCL drive enable (0 = SCL idles high)
//   sccb_data_out/_en  : SDA value / active-low SDA drive enable
//   sccb_data_in       : SDA pad readback
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high in IDLE and in the one-cycle
// DONE state. This lets a waiting command start with zero extra idle
// cycles. cmd_valid while busy is ignored.
//
// Timing: each bus phase is built from SCL quarter-periods of CLK_DIV clocks.
// A read puts a STOP after the address bytes. It then leaves the bus free for
// one full SCL period (GAP) before the repeated START. This gives
// 152 quarters per write and 200 per read.
//
// All outputs are flops. They are loaded from the decode of the next state,
// so they line up with the state register without a combinational path.
// -----------------------------------------------------------------------------
module sccb_master #(
   parameter int         CLK_DIV    = 125,
   parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_rw,
   input  logic [15:0] cmd_addr,
   input  logic [7:0]  cmd_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_nack,
   output logic        busy,
   output logic        sccb_clk,
   output logic        sccb_clk_en,
   output logic        sccb_data_out,
   output logic        sccb_data_en,
   input  logic        sccb_data_in
);

   localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BYTE,
      S_STOP,
      S_GAP,
      S_DONE
   } state_t;

   state_t         state, state_n;
   logic [DW-1:0]  div_cnt, div_n;
   logic [1:0]     quarter, quarter_n;
   logic [3:0]     bit_idx, bit_n;     // 0..7 data bits, 8 = ack bit
   logic [2:0]     byte_idx, byte_n;   // position in the transaction's byte list

   logic           cap_rw;
   logic [15:0]    cap_addr;
   logic [7:0]     cap_wdata;
   logic [7:0]     rx_shift;
   logic           nack_acc;

   logic           accept, quarter_end, phase_end, sample_now, rx_byte_now;
   logic           rx_byte_n;
   logic [7:0]     tx_byte;
   logic           scl_n, scl_en_n, dout_n, den_n, ready_n;

   assign accept      = cmd_valid & cmd_ready;
   assign quarter_end = (div_cnt == DIV_LAST);
   assign phase_end   = quarter_end && (quarter == 2'd3);
   // Byte 4 of a read is the slave-driven data byte.
   assign rx_byte_now = cap_rw && (byte_idx == 3'd4);
   // SDA is sampled on the last clk of the SCL-high q2.
   assign sample_now  = (state == S_BYTE) && (quarter == 2'd2) && quarter_end;

   always_comb begin
      state_n   = state;
      div_n     = '0;
      quarter_n = 2'd0;
      bit_n     = bit_idx;
      byte_n    = byte_idx;
      tx_byte   = 8'hFF;
      rx_byte_n = 1'b0;
      scl_n     = 1'b1;
      scl_en_n  = 1'b0;
      dout_n    = 1'b1;
      den_n     = 1'b1;
      ready_n   = 1'b0;

      if (state != S_IDLE && state != S_DONE) begin
         div_n     = quarter_end ? '0 : div_cnt + 1'b1;
         quarter_n = quarter_end ? quarter + 2'd1 : quarter;
      end

      case (state)
         S_IDLE, S_DONE: begin
            if (accept) begin
               state_n = S_START;
               bit_n   = 4'd0;
               byte_n  = 3'd0;
            end else begin
               state_n = S_IDLE;
            end
         end
         S_START: if (phase_end) begin
            state_n = S_BYTE;
            bit_n   = 4'd0;
         end
         S_BYTE: if (phase_end) begin
            if (bit_idx == 4'd8) begin
               bit_n  = 4'd0;
               byte_n = byte_idx + 3'd1;
               // Write ends after byte 3; a read stops after byte 2 (address
               // phase) and again after byte 4 (read data).
               if (cap_rw ? (byte_idx == 3'd2 || byte_idx == 3'd4) : (byte_idx == 3'd3))
                  state_n = S_STOP;
            end else begin
               bit_n = bit_idx + 4'd1;
            end
         end
         S_STOP: if (phase_end) begin
            state_n = (cap_rw && byte_idx == 3'd3) ? S_GAP : S_DONE;
         end
         S_GAP: if (phase_end) begin
            state_n = S_START;
         end
         default: state_n = S_IDLE;
      endcase

      // Output decode of the next state, registered below.
      case (byte_n)
         3'd0:    tx_byte = {SLAVE_ADDR, 1'b0};
         3'd1:    tx_byte = cap_addr[15:8];
         3'd2:    tx_byte = cap_addr[7:0];
         3'd3:    tx_byte = cap_rw ? {SLAVE_ADDR, 1'b1} : cap_wdata;
         default: tx_byte = 8'hFF;
      endcase
      rx_byte_n = cap_rw && (byte_n == 3'd4);
      ready_n   = (state_n == S_IDLE) || (state_n == S_DONE);

      case (state_n)
         S_START: begin
            scl_en_n = 1'b1;
            den_n    = 1'b0;
            dout_n   = (quarter_n < 2'd2);
            scl_n    = (quarter_n != 2'd3);
         end
         S_BYTE: begin
            scl_en_n = 1'b1;
            scl_n    = quarter_n[1];
            if (bit_n == 4'd8) begin
               // Ack slot: master releases for its own bytes, drives NA
               // (1) after the read byte.
               den_n  = ~rx_byte_n;
               dout_n = 1'b1;
            end else if (rx_byte_n) begin
               den_n  = 1'b1;
               dout_n = 1'b1;
            end else begin
               den_n  = 1'b0;
               dout_n = tx_byte[3'd7 - bit_n[2:0]];
            end
         end
         S_STOP: begin
            if (quarter_n != 2'd3) begin
               scl_en_n = 1'b1;
               den_n    = 1'b0;
               dout_n   = (quarter_n == 2'd2);
               scl_n    = (quarter_n != 2'd0);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state         <= S_IDLE;
         div_cnt       <= '0;
         quarter       <= 2'd0;
         bit_idx       <= 4'd0;
         byte_idx      <= 3'd0;
         cap_rw        <= 1'b0;
         cap_addr      <= 16'd0;
         cap_wdata     <= 8'd0;
         rx_shift      <= 8'd0;
         nack_acc      <= 1'b0;
         cmd_ready     <= 1'b1;
         busy          <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= 8'd0;
         rsp_nack      <= 1'b0;
         sccb_clk      <= 1'b1;
         sccb_clk_en   <= 1'b0;
         sccb_data_out <= 1'b1;
         sccb_data_en  <= 1'b1;
      end else begin
         state    <= state_n;
         div_cnt  <= div_n;
         quarter  <= quarter_n;
         bit_idx  <= bit_n;
         byte_idx <= byte_n;

         if (accept) begin
            cap_rw    <= cmd_rw;
            cap_addr  <= cmd_addr;
            cap_wdata <= cmd_wdata;
            nack_acc  <= 1'b0;
         end else if (sample_now) begin
            if (rx_byte_now && bit_idx != 4'd8)
               rx_shift <= {rx_shift[6:0], sccb_data_in};
            else if (!rx_byte_now && bit_idx == 4'd8)
               nack_acc <= nack_acc | sccb_data_in;
         end

         rsp_valid <= (state_n == S_DONE);
         if (state_n == S_DONE) begin
            rsp_nack <= nack_acc;
            if (cap_rw)
               rsp_rdata <= rx_shift;
         end

         cmd_ready     <= ready_n;
         busy          <= ~ready_n;
         sccb_clk      <= scl_n;
         sccb_clk_en   <= scl_en_n;
         sccb_data_out <= dout_n;
         sccb_data_en  <= den_n;
      end
   end

endmodule

// File: tb/tb_sccb_master.sv
// -----------------------------------------------------------------------------
// tb_sccb_master
// Bench for sccb_master with CLK_DIV = 4. The bench models an SDA pull-up
// and a simple camera slave. A bus monitor decodes START/STOP/bytes from the
// SCL/SDA lines. A transaction-level model builds the expected token list and
// the response (latency, nack, rdata) from each command and the slave setup.
// -----------------------------------------------------------------------------
module tb_sccb_master;

   localparam int CD = 4;
   localparam logic [10:0] TOK_S = {2'b01, 9'h000};
   localparam logic [10:0] TOK_P = {2'b10, 9'h000};

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic        cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
   logic [15:0] cmd_addr = 16'd0;
   logic [7:0]  cmd_wdata = 8'd0;
   logic        rsp_valid, rsp_nack, busy;
   logic [7:0]  rsp_rdata;
   logic        sccb_clk, sccb_clk_en, sccb_data_out, sccb_data_en;
   logic        slave_drive = 1'b1;
   logic        sda_line;

   assign sda_line = sccb_data_en ? slave_drive : sccb_data_out;

   sccb_master #(.CLK_DIV(CD), .SLAVE_ADDR(7'h3C)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_rw       (cmd_rw),
      .cmd_addr     (cmd_addr),
      .cmd_wdata    (cmd_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_nack     (rsp_nack),
      .busy         (busy),
      .sccb_clk     (sccb_clk),
      .sccb_clk_en  (sccb_clk_en),
      .sccb_data_out(sccb_data_out),
      .sccb_data_en (sccb_data_en),
      .sccb_data_in (sda_line)
   );

   // ---------------- scoreboard state ----------------
   int          n_cmp = 0;
   int          n_err = 0;
   logic [10:0] tok_q[$];     // expected bus tokens
   logic [31:0] exp_q[$];     // {7'b0, nack, rdata, latency[15:0]}
   int          acc_q[$];     // acceptance edge of each outstanding command
   logic [7:0]  model_rdata = 8'd0;
   logic        b2b_chk = 1'b0;

   // slave configuration
   logic        slv_present = 1'b1;
   logic [3:0]  slv_mask = 4'd0;   // bit i: NACK the i-th master-sent byte
   logic [7:0]  slv_rd = 8'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ready"},    cmd_ready,     1);
      check({tag, "_busy"},     busy,          0);
      check({tag, "_rsp_valid"}, rsp_valid,    0);
      check({tag, "_rdata"},    rsp_rdata,     0);
      check({tag, "_nack"},     rsp_nack,      0);
      check({tag, "_scl"},      sccb_clk,      1);
      check({tag, "_scl_en"},   sccb_clk_en,   0);
      check({tag, "_sda_out"},  sccb_data_out, 1);
      check({tag, "_sda_en"},   sccb_data_en,  1);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [10:0] tok_byte(input logic [7:0] b, input logic ninth);
      return {2'b00, b, ninth};
   endfunction

   function automatic logic ack_bit(input int i);
      return slv_present ? slv_mask[i] : 1'b1;
   endfunction

   task automatic model_cmd(input logic rw, input logic [15:0] addr, input logic [7:0] wd);
      logic       nack;
      logic [7:0] rdv;
      int         lat;
      if (!rw) begin
         tok_q.push_back(TOK_S);
         tok_q.push_back(tok_byte(8'h78, ack_bit(0)));
         tok_q.push_back(tok_byte(addr[15:8], ack_bit(1)));
         tok_q.push_back(tok_byte(addr[7:0], ack_bit(2)));
         tok_q.push_back(tok_byte(wd, ack_bit(3)));
         tok_q.push_back(TOK_P);
         lat = 152 * CD;
      end else begin
         rdv = slv_present ? slv_rd : 8'hFF;
         tok_q.push_back(TOK_S);
         tok_q.push_back(tok_byte(8'h78, ack_bit(0)));
         tok_q.push_back(tok_byte(addr[15:8], ack_bit(1)));
         tok_q.push_back(tok_byte(addr[7:0], ack_bit(2)));
         tok_q.push_back(TOK_P);
         tok_q.push_back(TOK_S);
         tok_q.push_back(tok_byte(8'h79, ack_bit(3)));
         tok_q.push_back(tok_byte(rdv, 1'b1));
         tok_q.push_back(TOK_P);
         lat = 200 * CD;
         model_rdata = rdv;
      end
      nack = ack_bit(0) | ack_bit(1) | ack_bit(2) | ack_bit(3);
      exp_q.push_back({7'd0, nack, model_rdata, lat[15:0]});
   endtask

   // ---------------- driver ----------------
   task automatic send(input logic rw, input logic [15:0] addr, input logic [7:0] wd, input logic hold);
      int waited = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_rw    = rw;
      cmd_addr  = addr;
      cmd_wdata = wd;
      while (!cmd_ready && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      if (!cmd_ready) begin
         check("accept_timeout", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      if (b2b_chk) check("b2b_accept_in_rsp_cycle", rsp_valid, 1);
      acc_q.push_back(cyc + 1);
      model_cmd(rw, addr, wd);
      @(negedge clk);
      if (!hold) begin
         cmd_valid = 1'b0;
         cmd_rw    = 1'($urandom_range(0, 1));
         cmd_addr  = 16'($urandom);
         cmd_wdata = 8'($urandom);
      end
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         check("rsp_timeout", exp_q.size(), 0);
         exp_q.delete();
         acc_q.delete();
         tok_q.delete();
      end
      repeat (2) @(negedge clk);
      check("tokens_left", tok_q.size(), 0);
   endtask

   // ---------------- bus monitor and slave model ----------------
   logic       m_scl, m_sda, scl_p = 1'b1, sda_p = 1'b1;
   logic [8:0] shreg = 9'd0;
   int         bit_cnt = 0, slv_byte = 0, midx = 0;
   logic       slv_read = 1'b0, rw_now;
   int         low_run = 0, last_low_run = 0;

   task automatic got_token(input logic [10:0] t);
      if (tok_q.size() == 0) check("bus_token_extra", t, 11'h7FF);
      else check("bus_token", t, tok_q.pop_front());
   endtask

   always @(negedge clk) begin
      m_scl = sccb_clk_en ? sccb_clk : 1'b1;
      m_sda = sda_line;
      if (sccb_clk_en !== 1'b1) low_run++;
      else begin
         if (low_run > 0) last_low_run = low_run;
         low_run = 0;
      end
      if (scl_p && m_scl && sda_p && !m_sda) begin
         got_token(TOK_S);
         bit_cnt = 0; slv_byte = 0; slv_read = 1'b0; slave_drive = 1'b1;
      end else if (scl_p && m_scl && !sda_p && m_sda) begin
         got_token(TOK_P);
         bit_cnt = 0; slave_drive = 1'b1;
      end else if (!scl_p && m_scl) begin
         shreg = {shreg[7:0], m_sda};
         bit_cnt++;
         if (bit_cnt == 9) begin
            got_token({2'b00, shreg});
            if (slv_byte == 0) slv_read = shreg[1];
            slv_byte++;
            bit_cnt = 0;
         end
      end else if (scl_p && !m_scl) begin
         // SCL just fell: set up the slave's drive for the next bit.
         slave_drive = 1'b1;
         if (slv_present) begin
            rw_now = (slv_byte == 0) ? shreg[0] : slv_read;
            if (bit_cnt == 8 && !(slv_read && slv_byte == 1)) begin
               midx = rw_now ? 3 : slv_byte;
               slave_drive = slv_mask[midx];
            end else if (slv_read && slv_byte == 1 && bit_cnt < 8) begin
               slave_drive = slv_rd[7 - bit_cnt];
            end
         end
      end
      scl_p = m_scl;
      sda_p = m_sda;
   end

   // ---------------- response checker ----------------
   always @(negedge clk) begin
      logic [31:0] e;
      int          a;
      if (rstn && rsp_valid === 1'b1) begin
         if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
         else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("rsp_latency", cyc - a, {16'd0, e[15:0]});
            check("rsp_nack",    rsp_nack, e[24]);
            check("rsp_rdata",   rsp_rdata, e[23:16]);
            check("rsp_ready",   cmd_ready, 1);
            check("rsp_busy",    busy, 0);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int a;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      check_idle_outputs("idle");

      // 1: write with ACKs
      slv_present = 1'b1; slv_mask = 4'd0;
      send(1'b0, 16'h3008, 8'h42, 1'b0);
      wait_done(1500);

      // 2: read, slave returns 0x56
      slv_rd = 8'h56;
      send(1'b1, 16'h300A, 8'h00, 1'b0);
      wait_done(1500);
      check("read_rdata_held", rsp_rdata, 8'h56);

      // 3: absent slave
      slv_present = 1'b0;
      send(1'b0, 16'h3103, 8'h11, 1'b0);
      wait_done(1500);
      check("absent_nack_held", rsp_nack, 1);
      check("absent_rdata_kept", rsp_rdata, 8'h56);

      // 4: back-to-back write then read with cmd_valid held
      slv_present = 1'b1; slv_rd = 8'hA7;
      send(1'b0, 16'h0102, 8'h5C, 1'b1);
      b2b_chk = 1'b1;
      send(1'b1, 16'h0304, 8'h00, 1'b0);
      b2b_chk = 1'b0;
      repeat (3) @(negedge clk);
      check("b2b_clk_en_gap", last_low_run, CD + 1);
      wait_done(2500);

      // 5: cmd_valid pulse while busy is ignored
      send(1'b0, 16'h1234, 8'h9A, 1'b0);
      repeat (100) @(negedge clk);
      cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 16'hBEEF; cmd_wdata = 8'h00;
      check("busy_ready_low", cmd_ready, 0);
      check("busy_high", busy, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_done(1500);

      // 6: reset during bit 5 of addr[7:0]
      send(1'b0, 16'h5A5A, 8'hC3, 1'b0);
      a = acc_q[0];
      while (cyc < a + 92 * CD + 1) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      tok_q.delete(); exp_q.delete(); acc_q.delete();
      model_rdata = 8'd0;
      check_idle_outputs("abort");
      repeat (800) @(negedge clk);
      send(1'b0, 16'h3008, 8'h7E, 1'b0);
      wait_done(1500);

      // randomized transactions
      for (int i = 0; i < 12; i++) begin
         slv_present = ($urandom_range(0, 7) != 0);
         slv_mask    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
         slv_rd      = 8'($urandom);
         send(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 1'b0);
         wait_done(2500);
      end

      check("final_exp_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
